im2col_mc: RTL and testbench
============================

Name: im2col_mc

Overview:
- Parametrised multi-channel im2col engine for the systolic datapath.
- On a start pulse, reads a CHANNELS x IMG_H x IMG_W image from shared scratch memory and writes the unrolled patch matrix at IM2COL_BASE.
- Supports configurable filter size, stride and zero padding.
- Sustains one element per cycle against a single-cycle-latency memory, and holds a level done flag for the systolic controller.

Parameters:
- IMG_W, 8: image width in pixels.
- IMG_H, 8: image height in pixels.
- CHANNELS, 1: input channel count (>=1).
- DATA_WIDTH, 8: element width.
- ADDR_WIDTH, 32: memory address width.
- FILTER_SIZE, 3: square kernel side K.
- STRIDE, 1: kernel step, applied in both x and y (>=1).
- PAD, 0: zero-padding border width on every side.
- IMG_BASE, 16'h0000: byte/element address of the image.
- IM2COL_BASE, 16'h2000: element address of the output matrix.

Ports:
- clk  in  1  system clock, rising edge.
- rst_im2col_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle start pulse; sampled only in IDLE.
- data_rd  in  DATA_WIDTH  read data; valid the cycle after addr_rd is presented.
- data_wr  out  DATA_WIDTH  write data.
- addr_wr  out  ADDR_WIDTH  write address.
- addr_rd  out  ADDR_WIDTH  read address.
- mem_wr_en  out  1  write strobe.
- busy  out  1  high while in RUN or FLUSH.
- im2col_done  out  1  level; high from completion until the next accepted start.

Behaviour:
- Derived sizes:
  - OUT_W = (IMG_W+2*PAD-K)/STRIDE+1; OUT_H likewise.
  - COLS = CHANNELS*K*K.
  - N = OUT_H*OUT_W*COLS.
  - Integer division; an elaboration error is raised if IMG+2*PAD < K.
- Image layout: element (c,y,x) at IMG_BASE + (c*IMG_H+y)*IMG_W + x.
- Output layout:
  - row r = oy*OUT_W+ox; col = c*K*K + ky*K + kx.
  - Address = IM2COL_BASE + r*COLS + col, so addr_wr is a linear counter 0..N-1 offset by IM2COL_BASE.
- Iteration order, outermost to innermost: oy, ox, c, ky, kx.
- Source pixel: iy = oy*STRIDE+ky-PAD, ix = ox*STRIDE+kx-PAD, computed signed. The pixel is a pad pixel if iy or ix falls outside [0,IMG-1].
- FSM states: IDLE, RUN, FLUSH, DONE.
  - IDLE: start=1 -> RUN; counters cleared; im2col_done cleared.
  - RUN: one element per cycle.
    - addr_rd is driven combinationally from the counters. For pad pixels addr_rd holds IMG_BASE, since reads have no side effects.
    - The pad flag and write index are registered into the stage-2 register.
    - After the element with index N-1 is issued -> FLUSH.
  - FLUSH: one cycle to drain stage 2 -> DONE.
  - DONE: im2col_done=1; start=1 -> RUN (restart, im2col_done drops the next cycle); otherwise stay.
- Stage 2, the cycle after issue:
  - mem_wr_en=1.
  - addr_wr = IM2COL_BASE + index.
  - data_wr = pad ? PAD_VALUE : data_rd.
- Timing, with start sampled at edge 0:
  - First mem_wr_en is high in cycle 2.
  - Last write is in cycle N+1.
  - im2col_done rises at edge N+2.
  - Total exactly N writes, with no gaps.
- start while in RUN or FLUSH is ignored.
- Reset values: mem_wr_en=0, im2col_done=0, busy=0, addr_rd=IMG_BASE, addr_wr=IM2COL_BASE, data_wr=0; state=IDLE.
- Reset asserted mid-operation: outputs go to reset values immediately (asynchronous), with no further writes. Memory contents already written are left as-is.
- Address arithmetic is done at ADDR_WIDTH and wraps modulo 2^ADDR_WIDTH.

Optional Feature:
- Macro IM2COL_PADVAL_EN.
- Defined: adds input port pad_val [DATA_WIDTH-1:0]. pad_val is sampled at the accepted start and held for the whole run; PAD_VALUE = that captured value.
- Undefined: no port; PAD_VALUE = 0.
- All other behaviour is identical in both builds.

Test Plan:
- Defaults, 8x8, C=1, K=3, S=1, P=0, image[i]=i:
  - exactly 324 writes.
  - row 0 = {0,1,2,8,9,10,16,17,18} at 0x2000..0x2008.
  - row 35 starts with 45 at 0x2000+315.
  - im2col_done rises at edge 326.
- PAD=1, other parameters default: 576 writes. Row 0 = {0,0,0,0,0,1,0,8,9}. Row 63 last element (addr 0x2000+575) = 0.
- STRIDE=2, P=0: OUT 3x3, 81 writes. Row 1 col 0 = 2. Row 3 col 0 = 16.
- CHANNELS=2, image[i]=i&0xFF: COLS=18. Row 0 col 9 = 64; row 0 col 17 = 82. Total 648 writes.
- Reset asserted at cycle 50 of a default run:
  - mem_wr_en drops immediately; im2col_done stays 0.
  - A fresh start then completes 324 writes.
  - A start pulse mid-run is ignored: still 324 writes.
- With IM2COL_PADVAL_EN, PAD=1, pad_val=0xA5 at start: row 0 = {A5,A5,A5,A5,0,1,A5,8,9}.

Source files
------------

// File: rtl/im2col_mc.sv
// ============================================================================
// im2col_mc : multi-channel im2col engine, one element per cycle, padding and
//             stride support. Optional build macro: IM2COL_PADVAL_EN.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module im2col_mc #(
    parameter int                    IMG_W       = 8,
    parameter int                    IMG_H       = 8,
    parameter int                    CHANNELS    = 1,
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    FILTER_SIZE = 3,
    parameter int                    STRIDE      = 1,
    parameter int                    PAD         = 0,
    parameter logic [ADDR_WIDTH-1:0] IMG_BASE    = 'h0000,
    parameter logic [ADDR_WIDTH-1:0] IM2COL_BASE = 'h2000
) (
    input  logic                  clk,
    input  logic                  rst_im2col_n,
    input  logic                  start,
`ifdef IM2COL_PADVAL_EN
    input  logic [DATA_WIDTH-1:0] pad_val,
`endif
    input  logic [DATA_WIDTH-1:0] data_rd,
    output logic [DATA_WIDTH-1:0] data_wr,
    output logic [ADDR_WIDTH-1:0] addr_wr,
    output logic [ADDR_WIDTH-1:0] addr_rd,
    output logic                  mem_wr_en,
    output logic                  busy,
    output logic                  im2col_done
);

    localparam int K     = FILTER_SIZE;
    localparam int OUT_W = (IMG_W + 2*PAD - K) / STRIDE + 1;
    localparam int OUT_H = (IMG_H + 2*PAD - K) / STRIDE + 1;
    localparam int COLS  = CHANNELS * K * K;
    localparam int N     = OUT_H * OUT_W * COLS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    generate
        if ((IMG_W + 2*PAD < K) || (IMG_H + 2*PAD < K)) begin : g_geom_check
            $error("im2col_mc: padded image smaller than filter");
        end
    endgenerate

    logic [1:0]            state_q, state_d;
    logic [31:0]           oy_q, ox_q, c_q, ky_q, kx_q;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [ADDR_WIDTH-1:0] addr_wr_q;
    logic                  wr_en_q, pad_q, done_q;
    logic [DATA_WIDTH-1:0] padv;

    logic                  issue, accept, last, pad_pix;
    logic                  kx_end, ky_end, c_end, ox_end;
    logic signed [31:0]    iy, ix, rd_off;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_im2col_n) begin
        if (!rst_im2col_n) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_FLUSH;
            S_FLUSH:            state_d = S_DONE;
            S_DONE:  if (start) state_d = S_RUN;
            default:            state_d = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        issue  = (state_q == S_RUN);
        busy   = (state_q == S_RUN) || (state_q == S_FLUSH);
        accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    end

    assign last   = (idx_q == ADDR_WIDTH'(N - 1));
    assign kx_end = (kx_q == 32'(K - 1));
    assign ky_end = (ky_q == 32'(K - 1));
    assign c_end  = (c_q  == 32'(CHANNELS - 1));
    assign ox_end = (ox_q == 32'(OUT_W - 1));

    // Source coordinates go negative inside the top/left pad border.
    assign iy      = $signed(oy_q) * STRIDE + $signed(ky_q) - PAD;
    assign ix      = $signed(ox_q) * STRIDE + $signed(kx_q) - PAD;
    assign pad_pix = (iy < 0) || (iy >= IMG_H) || (ix < 0) || (ix >= IMG_W);
    assign rd_off  = ($signed(c_q) * IMG_H + iy) * IMG_W + ix;
    assign addr_rd = (issue && !pad_pix) ? IMG_BASE + ADDR_WIDTH'(rd_off) : IMG_BASE;

    always_ff @(posedge clk or negedge rst_im2col_n) begin
        if (!rst_im2col_n) begin
            oy_q  <= '0;
            ox_q  <= '0;
            c_q   <= '0;
            ky_q  <= '0;
            kx_q  <= '0;
            idx_q <= '0;
        end else if (accept) begin
            oy_q  <= '0;
            ox_q  <= '0;
            c_q   <= '0;
            ky_q  <= '0;
            kx_q  <= '0;
            idx_q <= '0;
        end else if (issue) begin
            idx_q <= idx_q + 1'b1;
            kx_q  <= kx_end ? '0 : kx_q + 32'd1;
            if (kx_end) begin
                ky_q <= ky_end ? '0 : ky_q + 32'd1;
                if (ky_end) begin
                    c_q <= c_end ? '0 : c_q + 32'd1;
                    if (c_end) begin
                        ox_q <= ox_end ? '0 : ox_q + 32'd1;
                        if (ox_end) oy_q <= oy_q + 32'd1;
                    end
                end
            end
        end
    end

    // Stage 2: write strobe, pad flag and output address, one cycle after issue.
    always_ff @(posedge clk or negedge rst_im2col_n) begin
        if (!rst_im2col_n) begin
            wr_en_q   <= 1'b0;
            pad_q     <= 1'b0;
            addr_wr_q <= IM2COL_BASE;
            done_q    <= 1'b0;
        end else begin
            wr_en_q <= issue;
            pad_q   <= issue && pad_pix;
            if (issue) addr_wr_q <= IM2COL_BASE + idx_q;
            if (accept)                    done_q <= 1'b0;
            else if (state_q == S_DONE)    done_q <= 1'b1;
        end
    end

`ifdef IM2COL_PADVAL_EN
    logic [DATA_WIDTH-1:0] padv_q;
    always_ff @(posedge clk or negedge rst_im2col_n) begin
        if (!rst_im2col_n)  padv_q <= '0;
        else if (accept)    padv_q <= pad_val;
    end
    assign padv = padv_q;
`else
    assign padv = '0;
`endif

    assign mem_wr_en   = wr_en_q;
    assign addr_wr     = addr_wr_q;
    assign data_wr     = wr_en_q ? (pad_q ? padv : data_rd) : '0;
    assign im2col_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_im2col_mc.sv
// ============================================================================
// tb_im2col_mc : directed bench for im2col_mc across four geometries.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_im2col_mc;

`ifdef IM2COL_PADVAL_EN
    localparam logic [7:0] PADV = 8'hA5;
`else
    localparam logic [7:0] PADV = 8'h00;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic clr = 1'b1;
    logic [7:0] pad_val = 8'hA5;

    always #5 clk = ~clk;

    int nvec = 0;
    int nmis = 0;

    // Per-instance signals: 0 default, 1 PAD=1, 2 STRIDE=2, 3 CHANNELS=2
    logic [7:0]  rd   [4];
    logic [7:0]  dw   [4];
    logic [31:0] aw   [4];
    logic [31:0] ar   [4];
    logic        we   [4];
    logic        bsy  [4];
    logic        dn   [4];
    int          wcnt [4];
    int          serr [4];
    int          rise [4];

    logic [7:0] out0 [324];
    logic [7:0] out1 [576];
    logic [7:0] out2 [81];
    logic [7:0] out3 [648];

    im2col_mc u0 (.clk(clk), .rst_im2col_n(rst_n), .start(start),
`ifdef IM2COL_PADVAL_EN
        .pad_val(pad_val),
`endif
        .data_rd(rd[0]), .data_wr(dw[0]), .addr_wr(aw[0]), .addr_rd(ar[0]),
        .mem_wr_en(we[0]), .busy(bsy[0]), .im2col_done(dn[0]));

    im2col_mc #(.PAD(1)) u1 (.clk(clk), .rst_im2col_n(rst_n), .start(start),
`ifdef IM2COL_PADVAL_EN
        .pad_val(pad_val),
`endif
        .data_rd(rd[1]), .data_wr(dw[1]), .addr_wr(aw[1]), .addr_rd(ar[1]),
        .mem_wr_en(we[1]), .busy(bsy[1]), .im2col_done(dn[1]));

    im2col_mc #(.STRIDE(2)) u2 (.clk(clk), .rst_im2col_n(rst_n), .start(start),
`ifdef IM2COL_PADVAL_EN
        .pad_val(pad_val),
`endif
        .data_rd(rd[2]), .data_wr(dw[2]), .addr_wr(aw[2]), .addr_rd(ar[2]),
        .mem_wr_en(we[2]), .busy(bsy[2]), .im2col_done(dn[2]));

    im2col_mc #(.CHANNELS(2)) u3 (.clk(clk), .rst_im2col_n(rst_n), .start(start),
`ifdef IM2COL_PADVAL_EN
        .pad_val(pad_val),
`endif
        .data_rd(rd[3]), .data_wr(dw[3]), .addr_wr(aw[3]), .addr_rd(ar[3]),
        .mem_wr_en(we[3]), .busy(bsy[3]), .im2col_done(dn[3]));

    // Image memory holds image[i] = i & 0xFF, one-cycle read latency.
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) rd[j] <= ar[j][7:0];
    end

    // Output memories plus write-sequence tracking.
    always @(posedge clk) begin
        for (int j = 0; j < 4; j++) begin
            if (clr) begin
                wcnt[j] <= 0;
                serr[j] <= 0;
            end else if (we[j]) begin
                if (aw[j] !== 32'h2000 + 32'(wcnt[j])) serr[j] <= serr[j] + 1;
                wcnt[j] <= wcnt[j] + 1;
            end
        end
        if (we[0] && (aw[0] - 32'h2000) < 32'd324) out0[aw[0] - 32'h2000] <= dw[0];
        if (we[1] && (aw[1] - 32'h2000) < 32'd576) out1[aw[1] - 32'h2000] <= dw[1];
        if (we[2] && (aw[2] - 32'h2000) < 32'd81)  out2[aw[2] - 32'h2000] <= dw[2];
        if (we[3] && (aw[3] - 32'h2000) < 32'd648) out3[aw[3] - 32'h2000] <= dw[3];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Start is sampled at edge 0; the wait records the edge each done rises at.
    task automatic start_and_wait(input int bound, input bit poke_mid);
        for (int j = 0; j < 4; j++) rise[j] = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int e = 1; e <= bound; e++) begin
            @(posedge clk);
            #1;
            if (poke_mid && e == 60) start = 1'b1;
            if (e == 61) start = 1'b0;
            for (int j = 0; j < 4; j++)
                if (dn[j] && rise[j] < 0) rise[j] = e;
            if (rise[0] > 0 && rise[1] > 0 && rise[2] > 0 && rise[3] > 0) break;
        end
    endtask

    logic [7:0] exp0 [9];
    logic [7:0] exp1 [9];
    int wc_hold;

    initial begin
        exp0 = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
        exp1 = '{PADV, PADV, PADV, PADV, 8'd0, 8'd1, PADV, 8'd8, 8'd9};

        repeat (3) @(posedge clk);
        #1;
        check("rst_wr_en",   32'(we[0]),  32'd0);
        check("rst_done",    32'(dn[0]),  32'd0);
        check("rst_busy",    32'(bsy[0]), 32'd0);
        check("rst_addr_rd", ar[0],       32'h0000);
        check("rst_addr_wr", aw[0],       32'h2000);
        check("rst_data_wr", 32'(dw[0]),  32'd0);

        @(negedge clk); rst_n = 1'b1; clr = 1'b0;

        // Concurrent run of all geometries, with an ignored start mid-run.
        start_and_wait(800, 1'b1);
        #1;
        check("u0_writes", 32'(wcnt[0]), 32'd324);
        check("u0_seq",    32'(serr[0]), 32'd0);
        for (int i = 0; i < 9; i++) check($sformatf("u0_row0[%0d]", i), 32'(out0[i]), 32'(exp0[i]));
        check("u0_row35_col0", 32'(out0[315]), 32'd45);
        check("u0_done_edge",  32'(rise[0]),   32'd326);
        check("u0_busy_done",  32'(bsy[0]),    32'd0);

        check("u1_writes", 32'(wcnt[1]), 32'd576);
        check("u1_seq",    32'(serr[1]), 32'd0);
        for (int i = 0; i < 9; i++) check($sformatf("u1_row0[%0d]", i), 32'(out1[i]), 32'(exp1[i]));
        check("u1_row63_last", 32'(out1[575]), 32'(PADV));
        check("u1_done_edge",  32'(rise[1]),   32'd578);

        check("u2_writes",     32'(wcnt[2]), 32'd81);
        check("u2_seq",        32'(serr[2]), 32'd0);
        check("u2_row1_col0",  32'(out2[9]),  32'd2);
        check("u2_row3_col0",  32'(out2[27]), 32'd16);
        check("u2_done_edge",  32'(rise[2]),  32'd83);

        check("u3_writes",     32'(wcnt[3]), 32'd648);
        check("u3_seq",        32'(serr[3]), 32'd0);
        check("u3_row0_col9",  32'(out3[9]),  32'd64);
        check("u3_row0_col17", 32'(out3[17]), 32'd82);
        check("u3_done_edge",  32'(rise[3]),  32'd650);

        // Asynchronous reset partway through a run.
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (50) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en",   32'(we[0]),  32'd0);
        check("mid_rst_busy",    32'(bsy[0]), 32'd0);
        check("mid_rst_done",    32'(dn[0]),  32'd0);
        check("mid_rst_addr_wr", aw[0],       32'h2000);
        check("mid_rst_data_wr", 32'(dw[0]),  32'd0);
        wc_hold = wcnt[0];
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_no_writes", 32'(wcnt[0]), 32'(wc_hold));
        check("mid_rst_done_low",  32'(dn[0]),    32'd0);

        @(negedge clk); rst_n = 1'b1; clr = 1'b1;
        @(negedge clk); clr = 1'b0;
        start_and_wait(800, 1'b0);
        #1;
        check("rerun_writes",    32'(wcnt[0]), 32'd324);
        check("rerun_seq",       32'(serr[0]), 32'd0);
        check("rerun_row0_col4", 32'(out0[4]),   32'd9);
        check("rerun_row35",     32'(out0[315]), 32'd45);
        check("rerun_done_edge", 32'(rise[0]),   32'd326);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

`default_nettype wire
